// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button, then
// produces press/release strobes and a single long-press strobe per press.
module button_conditioner #(
  parameter int unsigned CLOCK_FREQ    = 100000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE
);

  localparam int unsigned DB_RAW          = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEBOUNCE_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int unsigned LONG_RAW        = (CLOCK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int unsigned LONG_CYCLES     = (LONG_RAW < 1) ? 1 : LONG_RAW;

  // Terminal values: the action fires on the edge that would complete the count.
  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic [1:0]  sync_reg;
  logic        sync;
  logic [31:0] db_cnt_reg, db_cnt_next;
  logic        level_reg, level_next;
  logic        toggle;
  logic        press_evt, release_evt;
  logic        press_reg, release_reg;
  state_t      state_reg, state_next;
  logic [31:0] hold_reg, hold_next;
  logic        long_reg, long_next;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], BTN_IN};
    end
  end

  assign sync = sync_reg[1];

  always_comb begin
    toggle      = 1'b0;
    level_next  = level_reg;
    db_cnt_next = '0;
    if (sync != level_reg) begin
      if (db_cnt_reg >= DB_LAST) begin
        toggle     = 1'b1;
        level_next = ~level_reg;
      end else begin
        db_cnt_next = db_cnt_reg + 32'd1;
      end
    end
  end

  // Edge events are taken from the toggle itself so the strobes and the FSM
  // react on the same edge that BTN_LEVEL changes.
  assign press_evt   = toggle & ~level_reg;
  assign release_evt = toggle &  level_reg;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      db_cnt_reg  <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      db_cnt_reg  <= db_cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_evt;
      release_reg <= release_evt;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      long_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      long_reg  <= long_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    long_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press_evt) begin
          state_next = HELD;
          hold_next  = '0;
        end
      end
      HELD: begin
        // Release wins over a terminal count landing on the same edge.
        if (release_evt) begin
          state_next = IDLE;
        end else if (level_reg) begin
          if (hold_reg >= LONG_LAST) begin
            long_next  = 1'b1;
            state_next = LONG;
          end
          if (hold_reg != CNT_MAX) begin
            hold_next = hold_reg + 32'd1;
          end
        end
      end
      LONG: begin
        if (release_evt) begin
          state_next = IDLE;
        end else if (level_reg && (hold_reg != CNT_MAX)) begin
          hold_next = hold_reg + 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
      end
    endcase
  end

  assign BTN_LEVEL     = level_reg;
  assign PRESS_PULSE   = press_reg;
  assign RELEASE_PULSE = release_reg;
  assign LONG_PULSE    = long_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based reference model checked every
// cycle, plus hand-computed pulse timings for directed button scenarios.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 10;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic BTN_IN = 1'b0;
  logic BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;
  logic m_bprev = 1'b0;
  logic hist[$];
  int   run = 0;
  bit   flip;

  // pulse log written by the compare process
  int press_cnt = 0, release_cnt = 0, long_cnt = 0;
  int press_edge = -1, release_edge = -1, long_edge = -1;

  button_conditioner #(
    .CLOCK_FREQ(1000),
    .DEBOUNCE_MS(4),
    .LONG_PRESS_MS(10)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .BTN_IN(BTN_IN),
    .BTN_LEVEL(BTN_LEVEL),
    .PRESS_PULSE(PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PULSE(LONG_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: the level flips once the last D synchronized samples all disagree
  // with it; long fires when the level has been 1 for L edges after the press.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RESETN) begin
        hist.delete();
        m_bprev = 1'b0; m_level = 1'b0; run = 0;
        m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      end else begin
        flip = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
        hist.push_back(m_bprev);
        if (hist.size() > D) void'(hist.pop_front());
        m_bprev   = BTN_IN;
        m_press   = flip && !m_level;
        m_release = flip && m_level;
        if (flip) m_level = ~m_level;
        run    = m_level ? run + 1 : 0;
        m_long = m_level && (run == L + 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (RESETN)
        check("outputs", {28'd0, BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE},
              {28'd0, m_level, m_press, m_release, m_long});
      else
        check("outputs_in_reset", {28'd0, BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE}, 32'd0);
      if (PRESS_PULSE === 1'b1)   begin press_cnt++;   press_edge = cyc;   end
      if (RELEASE_PULSE === 1'b1) begin release_cnt++; release_edge = cyc; end
      if (LONG_PULSE === 1'b1)    begin long_cnt++;    long_edge = cyc;    end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_log();
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    press_edge = -1; release_edge = -1; long_edge = -1;
  endtask

  // Hold BTN_IN high for hi_len cycles starting just after edge e0; offsets
  // are hand-computed edge distances from e0 (-1 means no pulse expected).
  task automatic press_case(input string name, input int hi_len,
                            input int exp_press, input int exp_release, input int exp_long);
    int e0;
    tick(1);
    clear_log();
    e0 = cyc;
    BTN_IN = 1'b1;
    tick(hi_len);
    BTN_IN = 1'b0;
    tick(25);
    $display("case %s: hi=%0d press@%0d release@%0d long@%0d (relative)", name, hi_len,
             press_edge - e0, release_edge - e0, long_edge - e0);
    check({name, "_press_cnt"}, press_cnt, 1);
    check({name, "_press_edge"}, press_edge - e0, exp_press);
    check({name, "_release_cnt"}, release_cnt, 1);
    check({name, "_release_edge"}, release_edge - e0, exp_release);
    if (exp_long < 0) begin
      check({name, "_long_cnt"}, long_cnt, 0);
    end else begin
      check({name, "_long_cnt"}, long_cnt, 1);
      check({name, "_long_edge"}, long_edge - e0, exp_long);
    end
  endtask

  initial begin
    int r;
    tick(3);
    check("reset_state", {28'd0, BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE}, 32'd0);
    RESETN = 1'b1;
    tick(5);

    press_case("short9", 9, 6, 15, -1);
    press_case("min4", 4, 6, 10, -1);
    press_case("long20", 20, 6, 26, 16);
    press_case("boundary10", 10, 6, 16, -1);
    press_case("past11", 11, 6, 17, 16);

    // bounce: runs shorter than the debounce window never reach the output
    tick(1);
    clear_log();
    BTN_IN = 1'b1; tick(3);
    BTN_IN = 1'b0; tick(2);
    BTN_IN = 1'b1; tick(2);
    BTN_IN = 1'b0; tick(20);
    $display("case bounce: presses=%0d releases=%0d longs=%0d", press_cnt, release_cnt, long_cnt);
    check("bounce_press_cnt", press_cnt, 0);
    check("bounce_release_cnt", release_cnt, 0);
    check("bounce_long_cnt", long_cnt, 0);
    check("bounce_level", {31'd0, BTN_LEVEL}, 32'd0);

    // reset in the middle of a held press, then recover with the button held
    tick(1);
    clear_log();
    r = cyc;
    BTN_IN = 1'b1;
    tick(12);
    check("midreset_pre_press_cnt", press_cnt, 1);
    check("midreset_pre_level", {31'd0, BTN_LEVEL}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("midreset_async_outputs", {28'd0, BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE}, 32'd0);
    clear_log();
    tick(3);
    RESETN = 1'b1;
    r = cyc;
    tick(8);
    BTN_IN = 1'b0;
    tick(20);
    $display("case midreset: press@%0d release@%0d longs=%0d (relative)", press_edge - r,
             release_edge - r, long_cnt);
    check("midreset_press_cnt", press_cnt, 1);
    check("midreset_press_edge", press_edge - r, 6);
    check("midreset_release_cnt", release_cnt, 1);
    check("midreset_release_edge", release_edge - r, 14);
    check("midreset_long_cnt", long_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
